// File: rtl/rx_downconverter.sv
// Receive-side fs/4 quadrature downconverter: undoes the 4-phase NCO rotation and
// integrates-and-dumps each NCO frame into one I/Q pair, with phase alignment and clip detect.
module rx_downconverter #(
  parameter int unsigned W = 18
) (
  input  logic                clk,
  input  logic                reset,
  input  logic signed [W-1:0] rx_in,
  input  logic [1:0]          phase_offset,
  input  logic                slip,
  input  logic                sym_clk_ena,
  input  logic                clr_clip,
  output logic signed [W-1:0] i_out,
  output logic signed [W-1:0] q_out,
  output logic                out_valid,
  output logic                out_sym,
  output logic                clip_flag
);

  localparam logic signed [W-1:0] MaxVal = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] MinVal = {1'b1, {(W-1){1'b0}}};

  logic [1:0]          cnt_q, cnt_d, ph;
  logic signed [W:0]   i_acc_q, i_acc_d, q_acc_q, q_acc_d;
  logic signed [W:0]   rx_ext, i_dump;
  logic signed [W-1:0] i_out_q, i_out_d, q_out_q, q_out_d;
  logic                sym_seen_q, sym_seen_d;
  logic                out_valid_q, out_valid_d, out_sym_q, out_sym_d;
  logic                clip_q, clip_d;
  logic                dump;
  logic                unused_lsb;

  assign rx_ext = {rx_in[W-1], rx_in};
  assign ph     = cnt_q + phase_offset;
  // Slip outranks the phase-3 dump; the dump then lands on the next cycle.
  assign dump   = ~slip & (ph == 2'd3);
  // The current phase-3 sample is folded straight into the dump.
  assign i_dump = i_acc_q - rx_ext;
  // Dropping the LSB of the W+1-bit sum is the floor-rounded arithmetic halving.
  assign unused_lsb = i_dump[0] ^ q_acc_q[0];

  always_comb begin
    cnt_d       = slip ? cnt_q : cnt_q + 2'd1;
    i_acc_d     = i_acc_q;
    q_acc_d     = q_acc_q;
    i_out_d     = i_out_q;
    q_out_d     = q_out_q;
    sym_seen_d  = sym_seen_q | sym_clk_ena;
    out_valid_d = dump;
    out_sym_d   = 1'b0;
    if (dump) begin
      i_acc_d    = '0;
      q_acc_d    = '0;
      i_out_d    = i_dump[W:1];
      q_out_d    = q_acc_q[W:1];
      out_sym_d  = sym_seen_q | sym_clk_ena;
      sym_seen_d = 1'b0;
    end else if (!slip) begin
      case (ph)
        2'd0:    q_acc_d = q_acc_q + rx_ext;
        2'd1:    i_acc_d = i_acc_q + rx_ext;
        2'd2:    q_acc_d = q_acc_q - rx_ext;
        default: ;
      endcase
    end
    if ((rx_in == MaxVal) || (rx_in == MinVal)) begin
      clip_d = 1'b1;
    end else if (clr_clip) begin
      clip_d = 1'b0;
    end else begin
      clip_d = clip_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q       <= '0;
      i_acc_q     <= '0;
      q_acc_q     <= '0;
      i_out_q     <= '0;
      q_out_q     <= '0;
      sym_seen_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_sym_q   <= 1'b0;
      clip_q      <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      i_acc_q     <= i_acc_d;
      q_acc_q     <= q_acc_d;
      i_out_q     <= i_out_d;
      q_out_q     <= q_out_d;
      sym_seen_q  <= sym_seen_d;
      out_valid_q <= out_valid_d;
      out_sym_q   <= out_sym_d;
      clip_q      <= clip_d;
    end
  end

  assign i_out     = i_out_q;
  assign q_out     = q_out_q;
  assign out_valid = out_valid_q;
  assign out_sym   = out_sym_q;
  assign clip_flag = clip_q;

endmodule

// File: tb/tb_rx_downconverter.sv
// Self-checking bench for rx_downconverter: a cycle model pushes expected dumps to a queue,
// each scenario pops and compares them when out_valid fires, plus fixed-value checks.
module tb_rx_downconverter;

  localparam int unsigned W = 18;

  logic                clk;
  logic                reset;
  logic signed [W-1:0] rx_in;
  logic [1:0]          phase_offset;
  logic                slip;
  logic                sym_clk_ena;
  logic                clr_clip;
  logic signed [W-1:0] i_out;
  logic signed [W-1:0] q_out;
  logic                out_valid;
  logic                out_sym;
  logic                clip_flag;

  rx_downconverter #(.W(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_in        (rx_in),
    .phase_offset (phase_offset),
    .slip         (slip),
    .sym_clk_ena  (sym_clk_ena),
    .clr_clip     (clr_clip),
    .i_out        (i_out),
    .q_out        (q_out),
    .out_valid    (out_valid),
    .out_sym      (out_sym),
    .clip_flag    (clip_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int i;
    int q;
    bit sym;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state (plain integers, no width wrap)
  int   m_cnt;
  int   m_i;
  int   m_q;
  bit   m_sym;
  bit   m_clip;
  bit   exp_v;

  int   pat[4] = '{100, 200, -100, -200};

  task automatic do_reset();
    reset = 1'b0;
    rx_in = '0;
    slip = 1'b0;
    sym_clk_ena = 1'b0;
    clr_clip = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    m_cnt = 0;
    m_i = 0;
    m_q = 0;
    m_sym = 0;
    m_clip = 0;
    exp_v = 0;
    exp_q.delete();
  endtask

  // Drive one sample, advance the model, step one clock, land #1 after the edge.
  task automatic step(input int x, input bit sl, input bit sym, input bit clr);
    int   ph;
    exp_t e;
    rx_in = x[W-1:0];
    slip = sl;
    sym_clk_ena = sym;
    clr_clip = clr;
    ph = (m_cnt + int'(phase_offset)) % 4;
    if (!sl && ph == 3) begin
      e.i = (m_i - x) >>> 1;
      e.q = m_q >>> 1;
      e.sym = m_sym | sym;
      exp_q.push_back(e);
      m_i = 0;
      m_q = 0;
      m_sym = 0;
      exp_v = 1;
    end else begin
      exp_v = 0;
      if (sym) m_sym = 1;
      if (!sl) begin
        case (ph)
          0: m_q = m_q + x;
          1: m_i = m_i + x;
          default: m_q = m_q - x;
        endcase
      end
    end
    if (!sl) m_cnt = (m_cnt + 1) % 4;
    if (x == -131072 || x == 131071) m_clip = 1;
    else if (clr) m_clip = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    rx_in = 18'sd1234;
    do_reset();
    do_reset();
    checks++;
    if (i_out !== '0 || q_out !== '0 || out_valid !== 1'b0 || out_sym !== 1'b0
        || clip_flag !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got i=%0d q=%0d v=%b s=%b c=%b want all 0",
               i_out, q_out, out_valid, out_sym, clip_flag);
    end
  endtask

  task automatic test_basic();
    exp_t e;
    int   first = -1;
    int   nval = 0;
    phase_offset = 2'd0;
    do_reset();
    for (int n = 0; n < 16; n++) begin
      step(pat[n % 4], 0, 0, 0);
      checks++;
      if (out_valid !== exp_v) begin
        errors++;
        $display("FAIL basic_valid cycle %0d got %b want %b", n, out_valid, exp_v);
      end
      if (out_valid === 1'b1 && exp_v) begin
        e = exp_q.pop_front();
        checks++;
        if (int'(i_out) !== e.i || int'(q_out) !== e.q || out_sym !== e.sym) begin
          errors++;
          $display("FAIL basic_data got %0d/%0d/%b want %0d/%0d/%b",
                   i_out, q_out, out_sym, e.i, e.q, e.sym);
        end
      end
      if (out_valid === 1'b1) begin
        nval++;
        if (first < 0) first = n + 1;
        checks++;
        if (i_out !== 18'sd200 || q_out !== 18'sd100) begin
          errors++;
          $display("FAIL basic_iq got %0d/%0d want 200/100", i_out, q_out);
        end
      end
    end
    checks++;
    if (first != 4 || nval != 4) begin
      errors++;
      $display("FAIL basic_timing got first=%0d count=%0d want 4/4", first, nval);
    end
  endtask

  task automatic test_extremes();
    exp_t e;
    int   stim[12] = '{0, 131071, 0, -131071,
                       0, -131072, 0, 131071,
                       131071, 0, -131072, 0};
    int   want_i[3] = '{131071, -131072, 0};
    int   want_q[3] = '{0, 0, 131071};
    phase_offset = 2'd0;
    do_reset();
    for (int n = 0; n < 12; n++) begin
      step(stim[n], 0, 0, 0);
      checks++;
      if (out_valid !== exp_v) begin
        errors++;
        $display("FAIL ext_valid cycle %0d got %b want %b", n, out_valid, exp_v);
      end
      if (out_valid === 1'b1 && exp_v) begin
        e = exp_q.pop_front();
        checks++;
        if (int'(i_out) !== e.i || int'(q_out) !== e.q) begin
          errors++;
          $display("FAIL ext_data got %0d/%0d want %0d/%0d", i_out, q_out, e.i, e.q);
        end
      end
      if (n % 4 == 3) begin
        checks++;
        if (int'(i_out) !== want_i[n / 4] || int'(q_out) !== want_q[n / 4]) begin
          errors++;
          $display("FAIL ext_fixed frame %0d got %0d/%0d want %0d/%0d",
                   n / 4, i_out, q_out, want_i[n / 4], want_q[n / 4]);
        end
      end
    end
    checks++;
    if (clip_flag !== 1'b1) begin
      errors++;
      $display("FAIL ext_clip got %b want 1", clip_flag);
    end
  endtask

  task automatic test_offset();
    exp_t e;
    int   nval = 0;
    phase_offset = 2'd1;
    do_reset();
    for (int n = 0; n < 16; n++) begin
      step(pat[n % 4], 0, 0, 0);
      checks++;
      if (out_valid !== exp_v) begin
        errors++;
        $display("FAIL off_valid cycle %0d got %b want %b", n, out_valid, exp_v);
      end
      if (out_valid === 1'b1 && exp_v) begin
        e = exp_q.pop_front();
        checks++;
        if (int'(i_out) !== e.i || int'(q_out) !== e.q) begin
          errors++;
          $display("FAIL off_data got %0d/%0d want %0d/%0d", i_out, q_out, e.i, e.q);
        end
      end
      if (out_valid === 1'b1) begin
        nval++;
        // First frame after reset is partial; later frames are full rotated frames.
        checks++;
        if (nval > 1 && (i_out !== 18'sd100 || q_out !== -18'sd200)) begin
          errors++;
          $display("FAIL off_iq got %0d/%0d want 100/-200", i_out, q_out);
        end else if (nval == 1 && (i_out !== 18'sd100 || q_out !== -18'sd100)) begin
          errors++;
          $display("FAIL off_first got %0d/%0d want 100/-100", i_out, q_out);
        end
      end
    end
    phase_offset = 2'd0;
  endtask

  task automatic test_slip();
    exp_t e;
    int   vcyc[$];
    phase_offset = 2'd0;
    do_reset();
    for (int n = 0; n < 18; n++) begin
      // Slip at cycle 6 (mid-frame) and cycle 12 (phase 3).
      step(pat[n % 4], (n == 6) || (n == 12), 0, 0);
      checks++;
      if (out_valid !== exp_v) begin
        errors++;
        $display("FAIL slip_valid cycle %0d got %b want %b", n, out_valid, exp_v);
      end
      if (out_valid === 1'b1 && exp_v) begin
        e = exp_q.pop_front();
        checks++;
        if (int'(i_out) !== e.i || int'(q_out) !== e.q) begin
          errors++;
          $display("FAIL slip_data got %0d/%0d want %0d/%0d", i_out, q_out, e.i, e.q);
        end
      end
      if (out_valid === 1'b1) vcyc.push_back(n + 1);
    end
    checks++;
    if (vcyc.size() != 4 || vcyc[0] != 4 || vcyc[1] != 9 || vcyc[2] != 14 || vcyc[3] != 18)
    begin
      errors++;
      $display("FAIL slip_timing got %0d pulses want pulses at 4,9,14,18", vcyc.size());
    end
  endtask

  task automatic test_clip();
    int  xs[5]  = '{0, -131072, 5, 5, 131071};
    bit  cl[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    bit  want[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    do_reset();
    for (int n = 0; n < 5; n++) begin
      step(xs[n], 0, 0, cl[n]);
      checks++;
      if (clip_flag !== want[n] || clip_flag !== m_clip) begin
        errors++;
        $display("FAIL clip step %0d got %b want %b", n, clip_flag, want[n]);
      end
    end
  endtask

  task automatic test_reset_midframe();
    exp_t e;
    phase_offset = 2'd0;
    do_reset();
    for (int n = 0; n < 6; n++) step(pat[n % 4], 0, 0, 0);
    reset = 1'b0;
    rx_in = 18'sd100;
    @(posedge clk);
    #1;
    checks++;
    if (i_out !== '0 || q_out !== '0 || out_valid !== 1'b0 || out_sym !== 1'b0) begin
      errors++;
      $display("FAIL midreset_state got %0d/%0d/%b/%b want 0/0/0/0",
               i_out, q_out, out_valid, out_sym);
    end
    reset = 1'b1;
    m_cnt = 0;
    m_i = 0;
    m_q = 0;
    m_sym = 0;
    exp_q.delete();
    for (int n = 0; n < 4; n++) begin
      step(pat[n], 0, 0, 0);
      checks++;
      if (out_valid !== (n == 3)) begin
        errors++;
        $display("FAIL midreset_valid cycle %0d got %b want %b", n, out_valid, n == 3);
      end
    end
    checks++;
    if (i_out !== 18'sd200 || q_out !== 18'sd100) begin
      errors++;
      $display("FAIL midreset_data got %0d/%0d want 200/100", i_out, q_out);
    end
  endtask

  task automatic test_sym();
    exp_t e;
    phase_offset = 2'd0;
    do_reset();
    for (int n = 0; n < 12; n++) begin
      // Strobe at frame cycle 1 of frame 2 and at the dump cycle of frame 3.
      step(pat[n % 4], 0, (n == 5) || (n == 11), 0);
      checks++;
      if (out_sym !== ((n == 7) || (n == 11))) begin
        errors++;
        $display("FAIL sym cycle %0d got %b want %b", n, out_sym, (n == 7) || (n == 11));
      end
      if (out_valid === 1'b1 && exp_v) begin
        e = exp_q.pop_front();
        checks++;
        if (out_sym !== e.sym || int'(i_out) !== e.i) begin
          errors++;
          $display("FAIL sym_data got %b/%0d want %b/%0d", out_sym, i_out, e.sym, e.i);
        end
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    rx_in = '0;
    phase_offset = 2'd0;
    slip = 1'b0;
    sym_clk_ena = 1'b0;
    clr_clip = 1'b0;
    #1;
    test_reset();
    test_basic();
    test_extremes();
    test_offset();
    test_slip();
    test_clip();
    test_reset_midframe();
    test_sym();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
